// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//   Time-multiplexes a 16x16 red/green LED board one row at a time. Each row
//   gets a blanking gap before it is lit, which prevents ghosting. Both pixel
//   frames are captured into shadow registers at every frame start, so a frame
//   never tears part-way through a scan.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   EN         in   scan enable; low forces the display dark
//   RedPixels  in   [15:0][15:0] red frame,   [row][col]
//   GrnPixels  in   [15:0][15:0] green frame, [row][col]
//   RowSink    out  one-hot row select (bit r = row r)
//   RedDriver  out  red column drive for the selected row
//   GrnDriver  out  green column drive for the selected row
//   RowIdx     out  row currently in BLANK or DRIVE
//   FrameStart out  one-cycle pulse on the first BLANK cycle of row 0
module led_matrix_scanner #(
    parameter int ROW_CYCLES   = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [15:0][15:0]  RedPixels,
    input  logic [15:0][15:0]  GrnPixels,
    output logic [15:0]        RowSink,
    output logic [15:0]        RedDriver,
    output logic [15:0]        GrnDriver,
    output logic [3:0]         RowIdx,
    output logic               FrameStart
);

    localparam int MAXC = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ROW_LAST   = CW'(ROW_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          row_q, row_d;
    logic [15:0][15:0]   shadow_red_q, shadow_red_d;
    logic [15:0][15:0]   shadow_grn_q, shadow_grn_d;
    logic [15:0]         sink_q, sink_d;
    logic [15:0]         red_q, red_d;
    logic [15:0]         grn_q, grn_d;
    logic                fs_q, fs_d;

    // Next-state, counter, row and shadow-load logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        shadow_red_d = shadow_red_q;
        shadow_grn_d = shadow_grn_q;

        unique case (state_q)
            IDLE: begin
                row_d = '0;
                cnt_d = '0;
                if (EN) begin
                    state_d      = BLANK;
                    shadow_red_d = RedPixels;
                    shadow_grn_d = GrnPixels;
                end
            end
            BLANK: begin
                if (!EN) begin
                    state_d = IDLE;
                    row_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRIVE: begin
                if (!EN) begin
                    state_d = IDLE;
                    row_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == ROW_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    row_d   = row_q + 4'd1;
                    // Leaving row 15 starts a new frame: take a fresh snapshot.
                    if (row_q == 4'd15) begin
                        shadow_red_d = RedPixels;
                        shadow_grn_d = GrnPixels;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so that the registered outputs
    // line up with the state they describe. Shadows never change on the edge
    // that enters DRIVE, so indexing the current shadow is safe here.
    always_comb begin
        sink_d = '0;
        red_d  = '0;
        grn_d  = '0;
        fs_d   = 1'b0;
        if (state_d == DRIVE) begin
            sink_d = 16'h0001 << row_d;
            red_d  = shadow_red_q[row_d];
            grn_d  = shadow_grn_q[row_d];
        end
        if (state_d == BLANK && state_q != BLANK && row_d == 4'd0)
            fs_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            shadow_red_q <= '0;
            shadow_grn_q <= '0;
            sink_q       <= '0;
            red_q        <= '0;
            grn_q        <= '0;
            fs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            shadow_red_q <= shadow_red_d;
            shadow_grn_q <= shadow_grn_d;
            sink_q       <= sink_d;
            red_q        <= red_d;
            grn_q        <= grn_d;
            fs_q         <= fs_d;
        end
    end

    assign RowSink    = sink_q;
    assign RedDriver  = red_q;
    assign GrnDriver  = grn_q;
    assign RowIdx     = row_q;
    assign FrameStart = fs_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
module tb_led_matrix_scanner;

    logic              CLK = 1'b0;
    logic              RST;
    logic              EN;
    logic [15:0][15:0] RedPixels;
    logic [15:0][15:0] GrnPixels;
    logic [15:0]       RowSink;
    logic [15:0]       RedDriver;
    logic [15:0]       GrnDriver;
    logic [3:0]        RowIdx;
    logic              FrameStart;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    led_matrix_scanner #(
        .ROW_CYCLES  (4),
        .BLANK_CYCLES(2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .RedPixels (RedPixels),
        .GrnPixels (GrnPixels),
        .RowSink   (RowSink),
        .RedDriver (RedDriver),
        .GrnDriver (GrnDriver),
        .RowIdx    (RowIdx),
        .FrameStart(FrameStart)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; observation happens 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        EN  = 1'b1;
        for (int r = 0; r < 16; r++) begin
            RedPixels[r] = 16'hFFFF;
            GrnPixels[r] = 16'hFFFF;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({RowSink, RedDriver, GrnDriver, RowIdx, FrameStart} !== 53'd0) begin
                errors++;
                $display("FAIL reset_outputs: sink=%h red=%h grn=%h row=%0d fs=%b, required all 0",
                         RowSink, RedDriver, GrnDriver, RowIdx, FrameStart);
            end
        end
    endtask

    // Startup, full frame, frame integrity and wrap in one continuous run.
    task automatic test_frame();
        logic [15:0] exp_sink, exp_red, exp_grn;
        logic [3:0]  exp_row;
        logic        exp_fs;
        int          p;
        for (int r = 0; r < 16; r++) begin
            RedPixels[r] = 16'h0001 << r;
            GrnPixels[r] = 16'h0000;
        end
        EN  = 1'b1;
        RST = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 104; c++) begin
            tick();
            if (cyc == 40)
                for (int r = 0; r < 16; r++) GrnPixels[r] = 16'hFFFF;
            // Position inside a frame: cycles 1..96 frame 1, 97.. frame 2.
            p        = (cyc - 1) % 96;
            exp_row  = 4'(p / 6);
            exp_fs   = (p == 0);
            exp_sink = '0;
            exp_red  = '0;
            exp_grn  = '0;
            if ((p % 6) >= 2) begin
                exp_sink = 16'h0001 << exp_row;
                exp_red  = 16'h0001 << exp_row;
                exp_grn  = (cyc > 96) ? 16'hFFFF : 16'h0000;
            end
            checks++;
            if (FrameStart !== exp_fs) begin
                errors++;
                $display("FAIL frame_start@%0d: got %b, required %b", cyc, FrameStart, exp_fs);
            end
            checks++;
            if (RowIdx !== exp_row) begin
                errors++;
                $display("FAIL row_idx@%0d: got %0d, required %0d", cyc, RowIdx, exp_row);
            end
            checks++;
            if (RowSink !== exp_sink) begin
                errors++;
                $display("FAIL row_sink@%0d: got %h, required %h", cyc, RowSink, exp_sink);
            end
            checks++;
            if (RedDriver !== exp_red) begin
                errors++;
                $display("FAIL red_driver@%0d: got %h, required %h", cyc, RedDriver, exp_red);
            end
            checks++;
            if (GrnDriver !== exp_grn) begin
                errors++;
                $display("FAIL grn_driver@%0d: got %h, required %h", cyc, GrnDriver, exp_grn);
            end
        end
    endtask

    task automatic test_en_drop();
        EN  = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        for (int r = 0; r < 16; r++) begin
            RedPixels[r] = 16'h1111;
            GrnPixels[r] = 16'h2222;
        end
        EN  = 1'b1;
        cyc = 0;
        while (cyc < 34) tick();
        checks++;
        if (RowSink !== 16'h0020 || RowIdx !== 4'd5 || RedDriver !== 16'h1111) begin
            errors++;
            $display("FAIL row5_drive: sink=%h row=%0d red=%h, required 0020 5 1111",
                     RowSink, RowIdx, RedDriver);
        end
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({RowSink, RedDriver, GrnDriver, RowIdx, FrameStart} !== 53'd0) begin
                errors++;
                $display("FAIL en_drop_idle%0d: sink=%h red=%h grn=%h row=%0d fs=%b, required all 0",
                         i, RowSink, RedDriver, GrnDriver, RowIdx, FrameStart);
            end
        end
        RedPixels[0] = 16'hA5A5;
        GrnPixels[0] = 16'h5A5A;
        EN = 1'b1;
        tick();
        checks++;
        if (FrameStart !== 1'b1 || RowIdx !== 4'd0 || RowSink !== 16'h0000) begin
            errors++;
            $display("FAIL reenable_fs: fs=%b row=%0d sink=%h, required 1 0 0000",
                     FrameStart, RowIdx, RowSink);
        end
        tick();
        checks++;
        if (FrameStart !== 1'b0 || RowSink !== 16'h0000) begin
            errors++;
            $display("FAIL reenable_blank: fs=%b sink=%h, required 0 0000", FrameStart, RowSink);
        end
        tick();
        checks++;
        if (RowSink !== 16'h0001 || RedDriver !== 16'hA5A5 || GrnDriver !== 16'h5A5A) begin
            errors++;
            $display("FAIL reenable_row0: sink=%h red=%h grn=%h, required 0001 a5a5 5a5a",
                     RowSink, RedDriver, GrnDriver);
        end
    endtask

    task automatic test_random_invariants();
        for (int c = 0; c < 3 * 96; c++) begin
            if (c % 37 == 0)
                for (int r = 0; r < 16; r++) begin
                    RedPixels[r] = 16'($urandom);
                    GrnPixels[r] = 16'($urandom);
                end
            tick();
            checks++;
            if (!$onehot0(RowSink)) begin
                errors++;
                $display("FAIL onehot_sink@%0d: got %h, required at most one bit", c, RowSink);
            end
            checks++;
            if (RowSink == 16'h0000 && (RedDriver !== 16'h0000 || GrnDriver !== 16'h0000)) begin
                errors++;
                $display("FAIL dark_drivers@%0d: red=%h grn=%h, required 0000 0000",
                         c, RedDriver, GrnDriver);
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        EN  = 1'b0;
        RedPixels = '0;
        GrnPixels = '0;
        test_reset();
        test_frame();
        test_en_drop();
        test_random_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Drives the 16x16 red/green LED board by time-multiplexing rows, with a blanking gap between rows to prevent ghosting.
- Takes the full-frame RedPixels/GrnPixels arrays from the pattern or game logic.
- Takes a snapshot of both arrays at each frame start, so a frame never tears mid-scan.
- Sits between the pixel-generating logic and the board pins.

Parameters:
- ROW_CYCLES, 1024, clock cycles each row is lit (>=1).
- BLANK_CYCLES, 16, clock cycles all rows are off before each row is lit (>=1).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  scan enable; low forces the display dark.
- RedPixels  in  [15:0][15:0]  red frame; RedPixels[r][c] = row r, column c.
- GrnPixels  in  [15:0][15:0]  green frame, same indexing.
- RowSink  out  16  one-hot active-high row select; bit r = row r.
- RedDriver  out  16  red column drive for the selected row; bit c = column c.
- GrnDriver  out  16  green column drive for the selected row.
- RowIdx  out  4  index of the row currently in BLANK or DRIVE.
- FrameStart  out  1  one-cycle pulse on the first BLANK cycle of row 0.

Behaviour:
- State machine: IDLE, BLANK, DRIVE.
- Counter width is $clog2(max(ROW_CYCLES, BLANK_CYCLES)+1).
- Shadow registers: ShadowRed[15:0][15:0] and ShadowGrn[15:0][15:0].
- Reset (RST=1 at an edge): state IDLE; RowIdx=0; RowSink, RedDriver, GrnDriver, FrameStart = 0; shadows cleared to 0; counter=0. RST overrides EN and any state.
- IDLE: all outputs 0; RowIdx=0.
  - EN=1 -> BLANK, row 0, counter cleared.
  - On that same edge, both input arrays are copied into the shadows.
- BLANK: RowSink, RedDriver, GrnDriver = 0.
  - FrameStart=1 only on the first BLANK cycle when RowIdx=0.
  - Lasts exactly BLANK_CYCLES cycles, then -> DRIVE with the same RowIdx.
- DRIVE: RowSink = 1<<RowIdx; RedDriver = ShadowRed[RowIdx]; GrnDriver = ShadowGrn[RowIdx].
  - All outputs are registered and valid from the first DRIVE cycle.
  - Lasts exactly ROW_CYCLES cycles, then -> BLANK with RowIdx+1.
- Wrap-around: DRIVE of row 15 -> BLANK of row 0 (RowIdx wraps 15 -> 0). On that edge the shadows reload from the inputs and FrameStart pulses on the next cycle.
- Input changes mid-frame have no effect on the displayed frame until the next frame start.
- Timing:
  - Frame period = 16*(BLANK_CYCLES+ROW_CYCLES) cycles.
  - First FrameStart appears 1 cycle after the EN rising edge is sampled in IDLE.
- EN=0 sampled in BLANK or DRIVE: -> IDLE on that edge; outputs 0 next cycle; RowIdx=0.
  - Shadows are kept, but a fresh snapshot is taken on re-entry.
  - Re-enable always restarts at row 0.
- At most one RowSink bit is ever high. RowSink and drivers are never nonzero in BLANK or IDLE.

Test Plan (ROW_CYCLES=4, BLANK_CYCLES=2; 6 cycles/row, 96 cycles/frame):
- Reset: hold RST 2 cycles with EN=1 and nonzero pixels -> all outputs 0, RowIdx=0, FrameStart=0 throughout.
- Startup and full frame:
  - Stimulus: RedPixels[r] = 16'h0001<<r, GrnPixels all 0, EN raised at cycle 0.
  - FrameStart=1 at cycle 1.
  - Cycles 3-6: RowSink=16'h0001, RedDriver=16'h0001.
  - Cycles 7-8: all 0.
  - Cycles 9-12: RowSink=16'h0002, RedDriver=16'h0002.
  - Next FrameStart at cycle 97.
- Frame integrity:
  - Stimulus: change GrnPixels to all 16'hFFFF at cycle 40 (mid-frame).
  - GrnDriver stays 0 for the rest of the frame.
  - GrnDriver=16'hFFFF during row 0 DRIVE of the next frame (cycles 99-102).
- Wrap: RowIdx sequence is 0..15 then 0; RowSink=16'h8000 during row-15 DRIVE, then 0 for 2 BLANK cycles, then 16'h0001.
- EN drop mid-DRIVE of row 5:
  - All outputs 0 on the next cycle; RowIdx=0.
  - On re-raise: FrameStart 1 cycle later, then row 0 displays the current inputs.
- Invariant check over 3 frames with random pixel data: $onehot0(RowSink) always; drivers are 0 whenever RowSink=0.
